// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider, h/v counters, sync and
// blanked colour pins, plus a frame tick and a slowed animation frame index.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned H_TOTAL      = 800,
  parameter int unsigned H_SYNC       = 96,
  parameter int unsigned H_DISP_START = 144,
  parameter int unsigned H_DISP_END   = 783,
  parameter int unsigned V_TOTAL      = 525,
  parameter int unsigned V_SYNC       = 2,
  parameter int unsigned V_DISP_START = 35,
  parameter int unsigned V_DISP_END   = 514,
  parameter int unsigned ANIM_DIV     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] rgb_in,
  output logic [9:0]  hCount,
  output logic [9:0]  vCount,
  output logic        bright,
  output logic        pix_en,
  output logic        hSync,
  output logic        vSync,
  output logic [3:0]  vgaR,
  output logic [3:0]  vgaG,
  output logic [3:0]  vgaB,
  output logic        frame_tick,
  output logic [6:0]  animation_frame_num
);

  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned ANIM_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  logic [DIV_W-1:0]  div;
  logic [DIV_W-1:0]  div_nxt;
  logic [ANIM_W-1:0] anim_cnt;
  logic              h_last;
  logic              v_last;

  // Divider wraps at CLK_DIV-1; pix_en is registered from the next count so
  // it is high exactly while div sits at CLK_DIV-1.
  always_comb begin
    div_nxt = div + DIV_W'(1);
    if (div == DIV_W'(CLK_DIV - 1)) begin
      div_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div    <= '0;
      pix_en <= 1'b0;
    end else begin
      div    <= div_nxt;
      pix_en <= (div_nxt == DIV_W'(CLK_DIV - 1));
    end
  end

  assign h_last = (hCount == 10'(H_TOTAL - 1));
  assign v_last = (vCount == 10'(V_TOTAL - 1));

  assign bright = (hCount >= 10'(H_DISP_START)) && (hCount <= 10'(H_DISP_END)) &&
                  (vCount >= 10'(V_DISP_START)) && (vCount <= 10'(V_DISP_END));

  // Raster position; vCount only moves on the pixel where hCount wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hCount <= '0;
      vCount <= '0;
    end else if (pix_en) begin
      hCount <= h_last ? 10'd0 : hCount + 10'd1;
      if (h_last) begin
        vCount <= v_last ? 10'd0 : vCount + 10'd1;
      end
    end
  end

  // Pins take the pre-increment position, so sync and colour stay aligned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hSync <= 1'b1;
      vSync <= 1'b1;
      vgaR  <= '0;
      vgaG  <= '0;
      vgaB  <= '0;
    end else if (pix_en) begin
      hSync <= ~(hCount < 10'(H_SYNC));
      vSync <= ~(vCount < 10'(V_SYNC));
      vgaR  <= bright ? rgb_in[11:8] : 4'h0;
      vgaG  <= bright ? rgb_in[7:4]  : 4'h0;
      vgaB  <= bright ? rgb_in[3:0]  : 4'h0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= pix_en && h_last && v_last;
    end
  end

  // Animation index advances once every ANIM_DIV frame ticks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      anim_cnt            <= '0;
      animation_frame_num <= '0;
    end else if (frame_tick) begin
      if (anim_cnt == ANIM_W'(ANIM_DIV - 1)) begin
        anim_cnt            <= '0;
        animation_frame_num <= animation_frame_num + 7'd1;
      end else begin
        anim_cnt <= anim_cnt + ANIM_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance and a shrunken-raster instance
// checked every cycle against an arithmetic model of elapsed clocks since reset.
module tb_vga_timing_gen;

  localparam int D0 = 4, HT0 = 800, HS0 = 96, HDS0 = 144, HDE0 = 783;
  localparam int VT0 = 525, VS0 = 2, VDS0 = 35, VDE0 = 514, AD0 = 8;
  localparam int D1 = 2, HT1 = 12, HS1 = 2, HDS1 = 3, HDE1 = 10;
  localparam int VT1 = 5, VS1 = 1, VDS1 = 1, VDE1 = 3, AD1 = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] rgb_in;

  logic [9:0] h0, v0, h1, v1;
  logic       br0, pe0, hs0, vs0, ft0, br1, pe1, hs1, vs1, ft1;
  logic [3:0] r0, g0, b0, r1, g1, b1;
  logic [6:0] an0, an1;

  int          vectors = 0;
  int          miscompares = 0;
  int          t = 0;
  logic [11:0] cap0, cap1;

  vga_timing_gen dut (
    .clk(clk), .rst(rst), .rgb_in(rgb_in), .hCount(h0), .vCount(v0), .bright(br0),
    .pix_en(pe0), .hSync(hs0), .vSync(vs0), .vgaR(r0), .vgaG(g0), .vgaB(b0),
    .frame_tick(ft0), .animation_frame_num(an0)
  );

  vga_timing_gen #(
    .CLK_DIV(D1), .H_TOTAL(HT1), .H_SYNC(HS1), .H_DISP_START(HDS1), .H_DISP_END(HDE1),
    .V_TOTAL(VT1), .V_SYNC(VS1), .V_DISP_START(VDS1), .V_DISP_END(VDE1), .ANIM_DIV(AD1)
  ) dut_s (
    .clk(clk), .rst(rst), .rgb_in(rgb_in), .hCount(h1), .vCount(v1), .bright(br1),
    .pix_en(pe1), .hSync(hs1), .vSync(vs1), .vgaR(r1), .vgaG(g1), .vgaB(b1),
    .frame_tick(ft1), .animation_frame_num(an1)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0d: got %h, wanted %h", name, t, act, exp);
    end
  endtask

  // Expected outputs after t clock edges since reset release.
  function automatic logic [43:0] model(input int tc, input int d, input int ht, input int hs,
      input int hds, input int hde, input int vt, input int vs, input int vds, input int vde,
      input int ad, input logic [11:0] cap);
    int n, h, v, hp, vp, fr, f;
    logic br, pe, hsy, vsy, ft, prev_vis;
    logic [11:0] col;
    fr  = ht * vt;
    n   = tc / d;
    h   = n % ht;
    v   = (n / ht) % vt;
    br  = (h >= hds) && (h <= hde) && (v >= vds) && (v <= vde);
    pe  = (tc % d) == d - 1;
    hsy = 1'b1;
    vsy = 1'b1;
    col = 12'h000;
    if (n > 0) begin
      hp       = (n - 1) % ht;
      vp       = ((n - 1) / ht) % vt;
      hsy      = !(hp < hs);
      vsy      = !(vp < vs);
      prev_vis = (hp >= hds) && (hp <= hde) && (vp >= vds) && (vp <= vde);
      col      = prev_vis ? cap : 12'h000;
    end
    ft = ((tc % d) == 0) && (n > 0) && ((n % fr) == 0);
    f  = (tc > 0) ? ((tc - 1) / (d * fr)) : 0;
    return {10'(h), 10'(v), br, pe, hsy, vsy, col, ft, 7'((f / ad) % 128)};
  endfunction

  // Elapsed-clock reference and the colour each instance saw on its last pixel edge.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      t <= 0;
    end else begin
      if (t % D0 == D0 - 1) cap0 <= rgb_in;
      if (t % D1 == D1 - 1) cap1 <= rgb_in;
      t <= t + 1;
    end
  end

  always @(negedge clk) begin
    check("cycle_full", 64'({h0, v0, br0, pe0, hs0, vs0, r0, g0, b0, ft0, an0}),
          64'(model(t, D0, HT0, HS0, HDS0, HDE0, VT0, VS0, VDS0, VDE0, AD0, cap0)));
    check("cycle_small", 64'({h1, v1, br1, pe1, hs1, vs1, r1, g1, b1, ft1, an1}),
          64'(model(t, D1, HT1, HS1, HDS1, HDE1, VT1, VS1, VDS1, VDE1, AD1, cap1)));
  end

  // Sync low widths in clocks, counted only for runs that began after reset.
  int   run_len[4] = '{0, 0, 0, 0};
  logic run_ok[4]  = '{1'b0, 1'b0, 1'b0, 1'b0};
  int   run_exp[4] = '{384, 6400, 4, 24};
  always @(negedge clk) begin
    logic [3:0] sg;
    sg = {vs1, hs1, vs0, hs0};
    for (int i = 0; i < 4; i++) begin
      if (!rst) begin
        run_len[i] = 0;
        run_ok[i]  = 1'b0;
      end else if (!sg[i]) begin
        run_len[i]++;
      end else begin
        if (run_ok[i] && run_len[i] > 0)
          check($sformatf("sync_width%0d", i), 64'(run_len[i]), 64'(run_exp[i]));
        run_len[i] = 0;
        run_ok[i]  = 1'b1;
      end
    end
  end

  // Small raster: tick spacing, animation steps and visible-window corners.
  int   gap = 0;
  int   ticks = 0;
  logic have_prev = 1'b0;
  logic pend = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      gap = 0; ticks = 0; have_prev = 1'b0; pend = 1'b0;
    end else begin
      if (pend) begin
        pend = 1'b0;
        case (ticks)
          1:       check("anim_k1", 64'(an1), 64'd0);
          2:       check("anim_k2", 64'(an1), 64'd1);
          255:     check("anim_k255", 64'(an1), 64'd127);
          256:     check("anim_k256", 64'(an1), 64'd0);
          default: ;
        endcase
      end
      gap++;
      if (ft1) begin
        if (have_prev) check("tick_gap", 64'(gap), 64'd120);
        have_prev = 1'b1;
        gap = 0;
        ticks++;
        pend = 1'b1;
      end
      if (h1 == 10'd3  && v1 == 10'd1) check("br_first", 64'(br1), 64'd1);
      if (h1 == 10'd10 && v1 == 10'd3) check("br_last", 64'(br1), 64'd1);
      if (h1 == 10'd2  && v1 == 10'd1) check("br_left", 64'(br1), 64'd0);
      if (h1 == 10'd11 && v1 == 10'd1) check("br_right", 64'(br1), 64'd0);
      if (h1 == 10'd3  && v1 == 10'd0) check("br_above", 64'(br1), 64'd0);
      if (h1 == 10'd3  && v1 == 10'd4) check("br_below", 64'(br1), 64'd0);
    end
  end

  // Colour stimulus rotates through a fixed table.
  initial begin
    logic [11:0] tbl[5];
    int idx;
    tbl = '{12'hF00, 12'h0F0, 12'h00F, 12'hABC, 12'hFFF};
    idx = 0;
    rgb_in = 12'hF00;
    forever begin
      repeat (50) @(negedge clk);
      idx = (idx + 1) % 5;
      rgb_in = tbl[idx];
    end
  end

  localparam logic [42:0] RST_VAL = {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 12'd0, 1'b0, 7'd0};

  task automatic reset_values(input string name);
    check({name, "_full"}, 64'({h0, v0, pe0, hs0, vs0, r0, g0, b0, ft0, an0}), 64'(RST_VAL));
    check({name, "_small"}, 64'({h1, v1, pe1, hs1, vs1, r1, g1, b1, ft1, an1}), 64'(RST_VAL));
  endtask

  task automatic startup_checks();
    @(posedge clk); #1;
    check("s_edge1", 64'({pe1, h1}), 64'({1'b1, 10'd0}));
    check("f_edge1", 64'(pe0), 64'd0);
    @(posedge clk); #1;
    check("s_edge2", 64'({pe1, h1}), 64'({1'b0, 10'd1}));
    check("f_edge2", 64'(pe0), 64'd0);
    @(posedge clk); #1;
    check("f_edge3", 64'({pe0, h0, hs0}), 64'({1'b1, 10'd0, 1'b1}));
    @(posedge clk); #1;
    check("f_edge4", 64'({pe0, h0, hs0}), 64'({1'b0, 10'd1, 1'b0}));
  endtask

  initial begin
    logic found;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    reset_values("hold_rst");
    rst = 1'b1;
    startup_checks();

    found = 1'b0;
    for (int i = 0; i < 40000 && !found; i++) begin
      @(negedge clk);
      if (h0 == 10'd799 && v0 == 10'd10 && pe0) found = 1'b1;
    end
    check("reach_799_10", 64'(found), 64'd1);
    @(negedge clk);
    check("line_wrap", 64'({h0, v0}), 64'({10'd0, 10'd11}));

    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      @(negedge clk);
      if (h0 == 10'd400) found = 1'b1;
    end
    check("reach_h400", 64'(found), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    reset_values("async_rst");
    repeat (10) @(negedge clk);
    rst = 1'b1;
    startup_checks();
    repeat (2000) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Generates 640x480@60 Hz VGA timing from the 100 MHz board clock. Drives the hCount/vCount/bright pixel-position interface that the block controller consumes. Registers the returned rgb onto the VGA pins with blanking applied. Also provides a frame tick and a slowed animation frame number for game-state and sprite logic.

Parameters:
CLK_DIV, 4, board clocks per pixel (pixel enable period)
H_TOTAL, 800, pixels per line including sync and porches
H_SYNC, 96, hSync low width in pixels, starting at hCount=0
H_DISP_START, 144, first visible hCount
H_DISP_END, 783, last visible hCount
V_TOTAL, 525, lines per frame
V_SYNC, 2, vSync low width in lines, starting at vCount=0
V_DISP_START, 35, first visible vCount
V_DISP_END, 514, last visible vCount
ANIM_DIV, 8, frames per animation_frame_num step

Ports:
clk  in  1  board clock, 100 MHz
rst  in  1  asynchronous, active-low reset
rgb_in  in  12  pixel colour from block controller, {R[3:0],G[3:0],B[3:0]}
hCount  out  10  horizontal pixel counter
vCount  out  10  vertical line counter
bright  out  1  high when (hCount,vCount) is inside the visible window
pix_en  out  1  one-clk strobe per pixel
hSync  out  1  VGA horizontal sync, active-low
vSync  out  1  VGA vertical sync, active-low
vgaR, vgaG, vgaB  out  4 each  registered pixel colour to pins
frame_tick  out  1  one-clk pulse at the end of each frame
animation_frame_num  out  7  animation frame index

Behaviour:
Reset values, asserted asynchronously when rst=0:
- divider=0, hCount=0, vCount=0, pix_en=0.
- hSync=1 and vSync=1 (inactive).
- vgaR/G/B=0, frame_tick=0, animation_frame_num=0, anim counter=0.

Divider:
- Counts 0..CLK_DIV-1 and wraps to 0.
- pix_en=1 for exactly the clk cycle in which the divider equals CLK_DIV-1. The first pix_en after reset release falls on the 4th clk edge.

Counters advance only on cycles where pix_en=1:
- hCount increments. At H_TOTAL-1 it wraps to 0.
- vCount increments only on the cycle hCount wraps. At V_TOTAL-1 it wraps to 0.
- vCount never changes on a cycle where hCount does not wrap.

bright:
- Combinational from the current counters.
- bright = (H_DISP_START<=hCount<=H_DISP_END) && (V_DISP_START<=vCount<=V_DISP_END).
- Window bounds are inclusive at both ends.

Pin outputs, registered on pix_en and computed from the pre-increment counter values:
- hSync <= ~(hCount < H_SYNC); vSync <= ~(vCount < V_SYNC).
- vga{R,G,B} <= bright ? rgb_in : 0. Colour is always black outside the visible window, whatever rgb_in holds.
- Latency: pins reflect a counter position one pixel (CLK_DIV clks) after hCount/vCount show it. Sync and colour stay mutually aligned.

frame_tick:
- =1 for one clk when pix_en=1 and hCount=H_TOTAL-1 and vCount=V_TOTAL-1, i.e. the same cycle both counters wrap.
- Registered, so it is visible in the following cycle.
- Period is CLK_DIV*H_TOTAL*V_TOTAL = 1,680,000 clks.

Animation counter:
- A 0..ANIM_DIV-1 counter increments on each frame_tick.
- When it wraps, animation_frame_num increments, wrapping 127 to 0.

Reset asserted mid-line or mid-frame:
- All state returns to reset values immediately, with no completion of the current line.
- After release, timing restarts from hCount=0, vCount=0. The first hSync low is output on the first pix_en.

Test Plan:
- Reset: hold rst=0 for 10 clks, then release -> all outputs at reset values during reset; pix_en first high on clk 4 after release, then every 4 clks; hCount 0->1 on that pix_en.
- Line wrap: run to hCount=799, vCount=10 -> next pix_en gives hCount=0, vCount=11; hSync low for exactly 96 pixels (384 clks) per line.
- Frame: run a full frame -> vSync low for exactly 2 lines (6400 clks); frame_tick single 1-clk pulse; two consecutive ticks 1,680,000 clks apart; hCount/vCount both 0 afterwards.
- Blanking: rgb_in=12'hF00 constant -> vgaR=4'hF only where the prior pixel had bright=1; bright=1 at (144,35) and (783,514), bright=0 at (143,35), (784,35), (144,34) and (144,515); pins 0 elsewhere.
- Animation: run 8 frames -> animation_frame_num 0->1 at the 8th frame_tick; preload near 127 and run 8 more frames -> wraps to 0.
- Mid-frame reset: assert rst=0 at hCount=400, vCount=200 -> counters, syncs and colour return to reset values within the same clk, without waiting for a clk edge; after release, sequence matches the Reset scenario.
